// File: rtl/udma_hyper_responder.sv
// HyperBus memory-device responder for loopback and bring-up of the uDMA HyperBus controller.
// Define HYPER_RESP_DOUBLE_LAT_EN to advertise and apply double initial latency.
module udma_hyper_responder #(
    parameter int MEM_DEPTH = 256,
    parameter int LATENCY   = 6
) (
    input  logic        sys_clk_i,
    input  logic        rstn_i,
    input  logic        hyper_reset_ni,
    input  logic        hyper_cs_ni,
    input  logic [15:0] hyper_dq_i,
    input  logic        hyper_dq_oe_i,
    input  logic [1:0]  hyper_rwds_i,
    input  logic        hyper_rwds_oe_i,
    output logic [15:0] hyper_dq_o,
    output logic        hyper_dq_oe_o,
    output logic [1:0]  hyper_rwds_o,
    output logic        hyper_rwds_oe_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int AW = $clog2(MEM_DEPTH);
`ifdef HYPER_RESP_DOUBLE_LAT_EN
    localparam int         LAT_CYC = 2 * LATENCY;
    localparam logic [1:0] CA_RWDS = 2'b11;
`else
    localparam int         LAT_CYC = LATENCY;
    localparam logic [1:0] CA_RWDS = 2'b00;
`endif
    localparam logic [15:0] CR0_RESET = 16'h8F1F;

    typedef enum logic [2:0] {IDLE, CA, LAT, RD, WR, REGWR, DRAIN} state_t;

    state_t        state;
    logic [15:0]   mem [MEM_DEPTH];
    logic [15:0]   ram_q;
    logic [15:0]   ca_hi;
    logic [15:0]   ca_mid;
    logic          ca_last;
    logic [7:0]    lat_cnt;
    logic [AW-1:0] addr;
    logic [15:0]   cr0;
    logic [31:0]   ca_addr;
    logic          mem_we;
    logic          unused_ok;

    // Word address is CA[44:16] concatenated with CA[2:0]; only the low AW bits index the RAM.
    assign ca_addr   = {ca_hi[12:0], ca_mid, hyper_dq_i[2:0]};
    assign mem_we    = (state == WR) && !hyper_cs_ni && hyper_reset_ni && hyper_dq_oe_i;
    assign unused_ok = ^{ca_addr[31:AW], hyper_rwds_oe_i};

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic lin);
        logic [AW-1:0] n;
        if (lin) begin
            n = a + AW'(1);
        end else begin
            n      = a;
            n[3:0] = a[3:0] + 4'd1;
        end
        return n;
    endfunction

    always_ff @(posedge sys_clk_i) begin
        if (mem_we) begin
            if (!hyper_rwds_i[1]) mem[addr][15:8] <= hyper_dq_i[15:8];
            if (!hyper_rwds_i[0]) mem[addr][7:0]  <= hyper_dq_i[7:0];
        end
        ram_q <= mem[addr];
    end

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state           <= IDLE;
            ca_hi           <= '0;
            ca_mid          <= '0;
            ca_last         <= 1'b0;
            lat_cnt         <= '0;
            addr            <= '0;
            cr0             <= CR0_RESET;
            err_o           <= 1'b0;
            busy_o          <= 1'b0;
            hyper_dq_o      <= '0;
            hyper_dq_oe_o   <= 1'b0;
            hyper_rwds_o    <= '0;
            hyper_rwds_oe_o <= 1'b0;
        end else if (!hyper_reset_ni || hyper_cs_ni) begin
            state           <= IDLE;
            busy_o          <= 1'b0;
            hyper_dq_o      <= '0;
            hyper_dq_oe_o   <= 1'b0;
            hyper_rwds_o    <= '0;
            hyper_rwds_oe_o <= 1'b0;
            if (!hyper_reset_ni) cr0 <= CR0_RESET;
        end else begin
            case (state)
                IDLE: begin
                    busy_o <= 1'b1;
                    if (!hyper_dq_oe_i) begin
                        err_o <= 1'b1;
                        state <= DRAIN;
                    end else begin
                        ca_hi           <= hyper_dq_i;
                        ca_last         <= 1'b0;
                        state           <= CA;
                        hyper_rwds_oe_o <= 1'b1;
                        hyper_rwds_o    <= CA_RWDS;
                    end
                end
                CA: begin
                    if (!hyper_dq_oe_i) begin
                        err_o           <= 1'b1;
                        state           <= DRAIN;
                        hyper_rwds_oe_o <= 1'b0;
                        hyper_rwds_o    <= '0;
                    end else if (!ca_last) begin
                        ca_mid  <= hyper_dq_i;
                        ca_last <= 1'b1;
                    end else begin
                        err_o           <= 1'b0;
                        hyper_rwds_oe_o <= 1'b0;
                        hyper_rwds_o    <= '0;
                        addr            <= ca_addr[AW-1:0];
                        if (ca_hi[14] && !ca_hi[15]) begin
                            state <= REGWR;
                        end else begin
                            state   <= LAT;
                            lat_cnt <= 8'(LAT_CYC - 1);
                        end
                    end
                end
                LAT: begin
                    // Reads start prefetching two cycles before the first data cycle.
                    if (ca_hi[15] && (lat_cnt <= 8'd1)) addr <= next_addr(addr, ca_hi[13]);
                    if (lat_cnt == 8'd0) begin
                        if (ca_hi[15]) begin
                            state           <= RD;
                            hyper_dq_o      <= ca_hi[14] ? cr0 : ram_q;
                            hyper_dq_oe_o   <= 1'b1;
                            hyper_rwds_o    <= 2'b10;
                            hyper_rwds_oe_o <= 1'b1;
                        end else begin
                            state <= WR;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 8'd1;
                    end
                end
                RD: begin
                    hyper_dq_o <= ca_hi[14] ? cr0 : ram_q;
                    addr       <= next_addr(addr, ca_hi[13]);
                end
                WR: begin
                    if (hyper_dq_oe_i) addr <= next_addr(addr, ca_hi[13]);
                end
                REGWR: begin
                    if (hyper_dq_oe_i) cr0 <= hyper_dq_i;
                    state <= DRAIN;
                end
                DRAIN: begin
                    state <= DRAIN;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udma_hyper_responder.sv
// Directed self-checking bench for udma_hyper_responder (honours HYPER_RESP_DOUBLE_LAT_EN).
module tb_udma_hyper_responder;

`ifdef HYPER_RESP_DOUBLE_LAT_EN
    localparam int         L     = 12;
    localparam logic [1:0] CA_RW = 2'b11;
`else
    localparam int         L     = 6;
    localparam logic [1:0] CA_RW = 2'b00;
`endif

    logic        clk        = 1'b0;
    logic        rstn       = 1'b0;
    logic        hrst_n     = 1'b1;
    logic        cs_n       = 1'b1;
    logic [15:0] dq_in      = '0;
    logic        dq_oe_in   = 1'b0;
    logic [1:0]  rwds_in    = '0;
    logic        rwds_oe_in = 1'b0;
    logic [15:0] dq_o;
    logic        dq_oe_o;
    logic [1:0]  rwds_o;
    logic        rwds_oe_o;
    logic        busy_o;
    logic        err_o;

    int checks = 0;
    int fails  = 0;

    logic [15:0] wr_words [16];
    logic [1:0]  wr_mask  [16];
    logic        wr_oe    [16];
    logic [15:0] rd_words [16];
    logic        rd_oe_ok;
    logic        pre_oe;
    logic [1:0]  ca_rwds;
    logic        ca_rwds_oe;
    logic        err_mid;
    logic        err_post;

    always #5 clk = ~clk;

    udma_hyper_responder #(.MEM_DEPTH(256), .LATENCY(6)) dut (
        .sys_clk_i(clk), .rstn_i(rstn), .hyper_reset_ni(hrst_n), .hyper_cs_ni(cs_n),
        .hyper_dq_i(dq_in), .hyper_dq_oe_i(dq_oe_in), .hyper_rwds_i(rwds_in),
        .hyper_rwds_oe_i(rwds_oe_in), .hyper_dq_o(dq_o), .hyper_dq_oe_o(dq_oe_o),
        .hyper_rwds_o(rwds_o), .hyper_rwds_oe_o(rwds_oe_o), .busy_o(busy_o), .err_o(err_o)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int i, input logic [15:0] w, input logic [1:0] m, input logic oe);
        wr_words[i] = w;
        wr_mask[i]  = m;
        wr_oe[i]    = oe;
    endtask

    // Drives c0..c2 and returns in the first cycle after c2 with DQ released.
    task automatic send_ca(input logic rd, input logic rg, input logic lin, input logic [31:0] a);
        logic [47:0] c;
        c = {rd, rg, lin, a[31:3], 13'd0, a[2:0]};
        cs_n = 1'b0; dq_oe_in = 1'b1; rwds_in = 2'b00; dq_in = c[47:32];
        cyc();
        ca_rwds = rwds_o; ca_rwds_oe = rwds_oe_o;
        dq_in = c[31:16];
        cyc();
        err_mid = err_o;
        dq_in = c[15:0];
        cyc();
        err_post = err_o;
        dq_oe_in = 1'b0; dq_in = '0;
    endtask

    // Ends in the cycle after cs rises, with a stray data word presented as cs goes high.
    task automatic do_write(input logic [31:0] a, input logic lin, input int n);
        send_ca(1'b0, 1'b0, lin, a);
        repeat (L) cyc();
        for (int i = 0; i < n; i++) begin
            dq_in = wr_words[i]; rwds_in = wr_mask[i]; dq_oe_in = wr_oe[i];
            cyc();
        end
        cs_n = 1'b1; dq_in = 16'hDEAD; rwds_in = 2'b00; dq_oe_in = 1'b1;
        cyc();
        dq_oe_in = 1'b0; dq_in = '0;
    endtask

    task automatic do_read(input logic rg, input logic lin, input logic [31:0] a, input int n);
        send_ca(1'b1, rg, lin, a);
        repeat (L - 1) cyc();
        pre_oe = dq_oe_o;
        cyc();
        rd_oe_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            rd_words[i] = dq_o;
            if (!(dq_oe_o === 1'b1 && rwds_oe_o === 1'b1 && rwds_o === 2'b10)) rd_oe_ok = 1'b0;
            cyc();
        end
        cs_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dq_o !== 16'h0) begin fails++; $display("FAIL reset_dq: got %h want 0000", dq_o); end
        checks++; if (dq_oe_o !== 1'b0) begin fails++; $display("FAIL reset_dq_oe: got %b want 0", dq_oe_o); end
        checks++; if (rwds_oe_o !== 1'b0) begin fails++; $display("FAIL reset_rwds_oe: got %b want 0", rwds_oe_o); end
        checks++; if (rwds_o !== 2'b00) begin fails++; $display("FAIL reset_rwds: got %b want 00", rwds_o); end
        checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err_o); end
        rstn = 1'b1;
        cyc();
    endtask

    task automatic test_linear();
        set_wr(0, 16'h1111, 2'b00, 1'b1); set_wr(1, 16'h2222, 2'b00, 1'b1);
        set_wr(2, 16'h3333, 2'b00, 1'b1); set_wr(3, 16'h4444, 2'b00, 1'b1);
        do_write(32'h010, 1'b1, 4);
        checks++; if (ca_rwds_oe !== 1'b1) begin fails++; $display("FAIL ca_rwds_oe: got %b want 1", ca_rwds_oe); end
        checks++; if (ca_rwds !== CA_RW) begin fails++; $display("FAIL ca_rwds: got %b want %b", ca_rwds, CA_RW); end
        checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL wr_end_busy: got %b want 0", busy_o); end
        do_read(1'b0, 1'b1, 32'h010, 4);
        checks++; if (pre_oe !== 1'b0) begin fails++; $display("FAIL rd_latency_early: got oe %b want 0", pre_oe); end
        checks++; if (rd_oe_ok !== 1'b1) begin fails++; $display("FAIL rd_drive: got %b want 1", rd_oe_ok); end
        checks++; if (rd_words[0] !== 16'h1111) begin fails++; $display("FAIL lin_rd0: got %h want 1111", rd_words[0]); end
        checks++; if (rd_words[1] !== 16'h2222) begin fails++; $display("FAIL lin_rd1: got %h want 2222", rd_words[1]); end
        checks++; if (rd_words[2] !== 16'h3333) begin fails++; $display("FAIL lin_rd2: got %h want 3333", rd_words[2]); end
        checks++; if (rd_words[3] !== 16'h4444) begin fails++; $display("FAIL lin_rd3: got %h want 4444", rd_words[3]); end
        checks++; if (dq_oe_o !== 1'b0 || dq_o !== 16'h0) begin fails++; $display("FAIL rd_release: got oe %b dq %h want 0 0000", dq_oe_o, dq_o); end
    endtask

    task automatic test_byte_mask();
        set_wr(0, 16'h0000, 2'b00, 1'b1);
        do_write(32'h020, 1'b1, 1);
        set_wr(0, 16'hABCD, 2'b01, 1'b1);
        do_write(32'h020, 1'b1, 1);
        do_read(1'b0, 1'b1, 32'h020, 1);
        checks++; if (rd_words[0] !== 16'hAB00) begin fails++; $display("FAIL byte_mask: got %h want ab00", rd_words[0]); end
    endtask

    task automatic test_wrapped();
        for (int i = 0; i < 16; i++) set_wr(i, 16'h0030 + 16'(i), 2'b00, 1'b1);
        do_write(32'h030, 1'b1, 16);
        do_read(1'b0, 1'b0, 32'h03E, 4);
        checks++; if (rd_words[0] !== 16'h003E) begin fails++; $display("FAIL wrap_rd0: got %h want 003e", rd_words[0]); end
        checks++; if (rd_words[1] !== 16'h003F) begin fails++; $display("FAIL wrap_rd1: got %h want 003f", rd_words[1]); end
        checks++; if (rd_words[2] !== 16'h0030) begin fails++; $display("FAIL wrap_rd2: got %h want 0030", rd_words[2]); end
        checks++; if (rd_words[3] !== 16'h0031) begin fails++; $display("FAIL wrap_rd3: got %h want 0031", rd_words[3]); end
    endtask

    task automatic test_linear_rollover();
        set_wr(0, 16'h5A5A, 2'b00, 1'b1); set_wr(1, 16'hA5A5, 2'b00, 1'b1);
        do_write(32'h10FF, 1'b1, 2);
        do_read(1'b0, 1'b1, 32'h100, 1);
        checks++; if (rd_words[0] !== 16'hA5A5) begin fails++; $display("FAIL rollover_wr: got %h want a5a5", rd_words[0]); end
        do_read(1'b0, 1'b1, 32'h0FF, 2);
        checks++; if (rd_words[0] !== 16'h5A5A) begin fails++; $display("FAIL rollover_rd0: got %h want 5a5a", rd_words[0]); end
        checks++; if (rd_words[1] !== 16'hA5A5) begin fails++; $display("FAIL rollover_rd1: got %h want a5a5", rd_words[1]); end
    endtask

    task automatic test_stall();
        set_wr(0, 16'h7001, 2'b00, 1'b1); set_wr(1, 16'hFFFF, 2'b00, 1'b0); set_wr(2, 16'h7002, 2'b00, 1'b1);
        do_write(32'h070, 1'b1, 3);
        do_read(1'b0, 1'b1, 32'h070, 2);
        checks++; if (rd_words[0] !== 16'h7001) begin fails++; $display("FAIL stall_rd0: got %h want 7001", rd_words[0]); end
        checks++; if (rd_words[1] !== 16'h7002) begin fails++; $display("FAIL stall_rd1: got %h want 7002", rd_words[1]); end
    endtask

    task automatic test_register();
        do_read(1'b1, 1'b1, 32'h0, 2);
        checks++; if (rd_words[1] !== 16'h8F1F) begin fails++; $display("FAIL cr0_default: got %h want 8f1f", rd_words[1]); end
        send_ca(1'b0, 1'b1, 1'b1, 32'h0);
        dq_in = 16'h8F17; dq_oe_in = 1'b1;
        cyc();
        dq_in = 16'h0BAD;
        cyc();
        cs_n = 1'b1; dq_oe_in = 1'b0; dq_in = '0;
        cyc();
        checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL regwr_busy: got %b want 0", busy_o); end
        do_read(1'b1, 1'b1, 32'h0, 3);
        checks++; if (pre_oe !== 1'b0) begin fails++; $display("FAIL reg_rd_latency: got oe %b want 0", pre_oe); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (rd_words[i] !== 16'h8F17) begin fails++; $display("FAIL cr0_rd%0d: got %h want 8f17", i, rd_words[i]); end
        end
        hrst_n = 1'b0;
        cyc();
        hrst_n = 1'b1;
        do_read(1'b1, 1'b1, 32'h0, 1);
        checks++; if (rd_words[0] !== 16'h8F1F) begin fails++; $display("FAIL cr0_dev_reset: got %h want 8f1f", rd_words[0]); end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 4; i++) set_wr(i, 16'h0000, 2'b00, 1'b1);
        do_write(32'h050, 1'b1, 4);
        set_wr(0, 16'hC001, 2'b00, 1'b1); set_wr(1, 16'hC002, 2'b00, 1'b1);
        do_write(32'h050, 1'b1, 2);
        checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", busy_o); end
        checks++; if (rwds_oe_o !== 1'b0 || dq_oe_o !== 1'b0) begin fails++; $display("FAIL abort_release: got rwds_oe %b dq_oe %b want 0 0", rwds_oe_o, dq_oe_o); end
        do_read(1'b0, 1'b1, 32'h050, 4);
        checks++; if (rd_words[0] !== 16'hC001) begin fails++; $display("FAIL abort_rd0: got %h want c001", rd_words[0]); end
        checks++; if (rd_words[1] !== 16'hC002) begin fails++; $display("FAIL abort_rd1: got %h want c002", rd_words[1]); end
        checks++; if (rd_words[2] !== 16'h0000) begin fails++; $display("FAIL abort_rd2: got %h want 0000", rd_words[2]); end
        checks++; if (rd_words[3] !== 16'h0000) begin fails++; $display("FAIL abort_rd3: got %h want 0000", rd_words[3]); end
        send_ca(1'b1, 1'b0, 1'b1, 32'h050);
        repeat (2) cyc();
        cs_n = 1'b1;
        cyc();
        checks++; if (busy_o !== 1'b0 || dq_oe_o !== 1'b0) begin fails++; $display("FAIL lat_abort: got busy %b dq_oe %b want 0 0", busy_o, dq_oe_o); end
    endtask

    task automatic test_proto_err();
        set_wr(0, 16'h1234, 2'b00, 1'b1);
        do_write(32'h060, 1'b1, 1);
        cs_n = 1'b0; dq_oe_in = 1'b1; dq_in = 16'h2000;
        cyc();
        dq_oe_in = 1'b0; dq_in = 16'h0000;
        cyc();
        checks++; if (err_o !== 1'b1) begin fails++; $display("FAIL err_set: got %b want 1", err_o); end
        checks++; if (rwds_oe_o !== 1'b0 || dq_oe_o !== 1'b0) begin fails++; $display("FAIL err_release: got rwds_oe %b dq_oe %b want 0 0", rwds_oe_o, dq_oe_o); end
        dq_oe_in = 1'b1; dq_in = 16'hFFFF;
        repeat (L + 3) cyc();
        cs_n = 1'b1; dq_oe_in = 1'b0; dq_in = '0;
        cyc();
        hrst_n = 1'b0;
        cyc();
        hrst_n = 1'b1;
        checks++; if (err_o !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", err_o); end
        do_read(1'b0, 1'b1, 32'h060, 1);
        checks++; if (err_mid !== 1'b1) begin fails++; $display("FAIL err_before_c2: got %b want 1", err_mid); end
        checks++; if (err_post !== 1'b0) begin fails++; $display("FAIL err_clear_c2: got %b want 0", err_post); end
        checks++; if (rd_words[0] !== 16'h1234) begin fails++; $display("FAIL err_no_write: got %h want 1234", rd_words[0]); end
    endtask

    task automatic test_async_reset();
        send_ca(1'b1, 1'b0, 1'b1, 32'h010);
        repeat (L + 1) cyc();
        #2 rstn = 1'b0;
        #1;
        checks++; if (dq_oe_o !== 1'b0 || busy_o !== 1'b0) begin fails++; $display("FAIL async_reset: got dq_oe %b busy %b want 0 0", dq_oe_o, busy_o); end
        cs_n = 1'b1;
        cyc();
        rstn = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_linear();
        test_byte_mask();
        test_wrapped();
        test_linear_rollover();
        test_stall();
        test_register();
        test_abort();
        test_proto_err();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/udma_hyper_responder.md
Name: udma_hyper_responder

Overview:
- Synthesizable HyperBus memory-device responder: the target-side counterpart of the uDMA HyperBus controller.
- Connects directly to the controller's digital pad-side signals (16-bit DQ word per sys_clk cycle = one CK period; [15:8] rising-edge byte, [7:0] falling-edge byte). Used for on-chip loopback, FPGA bring-up and controller regression without a physical HyperRAM.
- Decodes the 48-bit command/address, applies initial latency, serves linear/wrapped bursts from internal RAM and implements one configuration register (CR0).

Parameters:
- MEM_DEPTH, 256, number of 16-bit words in internal RAM (power of 2, >=16)
- LATENCY, 6, initial latency in clock cycles for memory-space accesses

Ports:
- sys_clk_i  input  1  clock
- rstn_i  input  1  asynchronous active-low reset
- hyper_reset_ni  input  1  device reset from controller, active-low, sampled synchronously
- hyper_cs_ni  input  1  chip select, active-low
- hyper_dq_i  input  16  DQ word from controller
- hyper_dq_oe_i  input  1  controller driving DQ
- hyper_rwds_i  input  2  write byte mask ([1]->dq[15:8], [0]->dq[7:0]; 1 = masked)
- hyper_rwds_oe_i  input  1  controller driving RWDS
- hyper_dq_o  output  16  read data word
- hyper_dq_oe_o  output  1  responder driving DQ
- hyper_rwds_o  output  2  latency indication / read strobe
- hyper_rwds_oe_o  output  1  responder driving RWDS
- busy_o  output  1  FSM not IDLE
- err_o  output  1  sticky command protocol error

Behaviour:
- Reset: rstn_i asynchronous, active-low; clock sys_clk_i. All outputs 0, FSM IDLE, CR0 = 16'h8F1F. RAM contents not reset. hyper_reset_ni low has the same effect synchronously, except err_o is kept.
- FSM states: IDLE, CA, LAT, RD, WR, REGWR, DRAIN.
- IDLE->CA on the first cycle with hyper_cs_ni=0. CA captures 3 words in cycles c0..c2 (MSW first) into CA[47:0].
- Decode: CA[47]=1 read; CA[46]=1 register space; CA[45]=1 linear, 0 wrapped. Word address = {CA[44:16],CA[2:0]} mod MEM_DEPTH.
- During CA, responder drives hyper_rwds_oe_o=1, hyper_rwds_o per Optional Feature.
- If hyper_dq_oe_i=0 in any CA cycle -> err_o=1, go DRAIN (outputs released, ignore bus until cs high). err_o clears on the next error-free c2.
- After c2:
  - memory read/write and register read -> LAT for L cycles (L per Optional Feature);
  - register write -> REGWR with zero latency: the next cycle's word is written to CR0 if hyper_dq_oe_i=1 (mask ignored), then DRAIN.
- Reads: first data word on hyper_dq_o in cycle c2+L+1. dq_oe_o=1, rwds_oe_o=1, rwds_o=2'b10 in every RD cycle. One word per cycle; register-space read returns CR0 every cycle.
- Writes: from cycle c2+L+1, each cycle with hyper_dq_oe_i=1 writes unmasked bytes and advances the address. Cycles with hyper_dq_oe_i=0 are stalls (no write, no advance).
- Address advance:
  - linear: +1 mod MEM_DEPTH;
  - wrapped: low 4 bits increment mod 16 within the aligned 16-word group, upper bits fixed.
- Internal RAM is synchronous with 1-cycle read latency. Next-address prefetch is issued one cycle early so RD delivers back-to-back words with no bubbles.
- hyper_cs_ni=1 in any state -> IDLE next cycle; dq_oe_o, rwds_oe_o, dq_o, rwds_o all 0 that cycle. A cs high during LAT or mid-burst aborts cleanly; no partial write after the last sampled data cycle.
- busy_o = (state != IDLE), registered.
- Responder never drives DQ while hyper_dq_oe_i=1; a simultaneous drive is impossible by construction.

Optional Feature:
- Macro HYPER_RESP_DOUBLE_LAT_EN.
- Defined: rwds_o=2'b11 during CA (double latency requested); L = 2*LATENCY for memory accesses and register reads.
- Undefined: rwds_o=2'b00 during CA; L = LATENCY.

Test Plan:
- Linear write then read: CA write mem addr 0x010, 4 words 1111/2222/3333/4444 -> read same addr with 4 data cycles returns identical words; first word at c2+7 (LATENCY=6, macro off) or c2+13 (macro on).
- Byte mask: write 0xABCD to 0x020 with rwds_i=2'b01 over prior 0x0000 -> read returns 0xAB00.
- Wrapped read: preload 0x030..0x03F with value = address, wrapped read from 0x03E, 4 words -> 0x03E, 0x03F, 0x030, 0x031.
- Register space: zero-latency write 0x8F17 to CR0 -> register read returns 0x8F17 every data cycle. Assert hyper_reset_ni -> CR0 reads 0x8F1F.
- Abort: raise cs_ni after 2 of 4 write data cycles -> only 2 words modified; busy_o=0 and outputs released the following cycle.
- Protocol error: dq_oe_i=0 in c1 -> err_o=1, no memory update, outputs released. The next valid command completes and clears err_o at its c2.
